// File: rtl/sprite_engine_multi.sv
// Multi-object sprite renderer: shadow OAM, fixed priority, colour keying,
// sticky bounding-box collision flags, 2-clock pixel pipeline.
//
// Ports:
//   clk, rst_n       pixel clock, synchronous active-low reset
//   video_on, x, y   current pixel from the VGA timing generator
//   frame_start      1-cycle pulse, copies oam_data into shadow OAM
//   oam_data         NUM_SPRITES packed 32-bit OAM entries
//   rom_type/x/y     external sprite ROM address (bank, column, row)
//   rom_color        ROM data, valid one clock after the address
//   coll_clr         clears collision_mask (new overlaps still set)
//   sprite_on, color drawn pixel and its colour (0 when not drawn)
//   collision_mask   sticky per-sprite overlap flags
module sprite_engine_multi #(
    parameter int          NUM_SPRITES = 8,
    parameter int          SPRITE_SIZE = 32,
    parameter int          ROM_AW      = 7,
    parameter logic [11:0] TRANSPARENT = 12'h00F
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     video_on,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic                     frame_start,
    input  logic [32*NUM_SPRITES-1:0] oam_data,
    output logic [1:0]               rom_type,
    output logic [ROM_AW-1:0]        rom_x,
    output logic [ROM_AW-1:0]        rom_y,
    input  logic [11:0]              rom_color,
    input  logic                     coll_clr,
    output logic                     sprite_on,
    output logic [11:0]              color,
    output logic [NUM_SPRITES-1:0]   collision_mask
);

    localparam int SW = $clog2(SPRITE_SIZE);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);

    // Shadow OAM and pipeline state
    logic [32*NUM_SPRITES-1:0] shadow_q;
    logic                      s1_hit_q;
    logic                      s2_hit_q;
    logic [1:0]                rom_type_q, rom_type_d;
    logic [ROM_AW-1:0]         rom_x_q, rom_x_d;
    logic [ROM_AW-1:0]         rom_y_q, rom_y_d;
    logic                      sprite_on_q, sprite_on_d;
    logic [11:0]               color_q, color_d;
    logic [NUM_SPRITES-1:0]    coll_q, coll_d;

    // Per-entry hit test against the shadow copy
    logic [NUM_SPRITES-1:0] hit;
    logic [SW-1:0]          dx [NUM_SPRITES];
    logic [SW-1:0]          dy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] oam_unused;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [9:0]  px;
        logic [9:0]  py;
        logic        en;
        logic [10:0] x11;
        logic [10:0] y11;
        logic        in_x;
        logic        in_y;

        assign px  = shadow_q[32*g+18 +: 10];
        assign py  = shadow_q[32*g+8 +: 10];
        assign en  = shadow_q[32*g+28];
        assign x11 = {1'b0, x};
        assign y11 = {1'b0, y};

        // 11-bit bounds so a sprite near the right edge never wraps to x=0
        assign in_x = (x11 >= {1'b0, px}) && (x11 < ({1'b0, px} + SIZE11));
        assign in_y = (y11 >= {1'b0, py}) && (y11 < ({1'b0, py} + SIZE11));

        assign hit[g] = video_on & en & in_x & in_y;
        assign dx[g]  = SW'(x - px);
        assign dy[g]  = SW'(y - py);

        assign oam_unused[g] = ^{shadow_q[32*g+31], shadow_q[32*g+6 +: 2]};
    end

    // Lowest index wins
    logic          sel_found;
    logic [IW-1:0] sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Two or more hits: clearing the lowest set bit leaves something
    logic multi_hit;
    assign multi_hit = |(hit & (hit - 1'b1));

    logic [2:0]    sel_row;
    logic [2:0]    sel_col;
    logic [SW+2:0] full_x;
    logic [SW+2:0] full_y;

    always_comb begin
        sel_row = shadow_q[32*sel_idx+3 +: 3];
        sel_col = shadow_q[32*sel_idx +: 3];
        full_x  = {sel_col, dx[sel_idx]};
        full_y  = {sel_row, dy[sel_idx]};

        rom_type_d = rom_type_q;
        rom_x_d    = rom_x_q;
        rom_y_d    = rom_y_q;
        if (sel_found) begin
            rom_type_d = shadow_q[32*sel_idx+29 +: 2];
            rom_x_d    = ROM_AW'(full_x);
            rom_y_d    = ROM_AW'(full_y);
        end
    end

    // Winning sprite's transparent pixel shows background, never a lower entry
    always_comb begin
        sprite_on_d = s2_hit_q && (rom_color != TRANSPARENT);
        color_d     = sprite_on_d ? rom_color : 12'h000;
    end

    // Clear and set on one edge: the new overlap bits survive the clear
    always_comb begin
        coll_d = coll_clr ? '0 : coll_q;
        if (multi_hit) begin
            coll_d = coll_d | hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            s1_hit_q    <= 1'b0;
            s2_hit_q    <= 1'b0;
            rom_type_q  <= '0;
            rom_x_q     <= '0;
            rom_y_q     <= '0;
            sprite_on_q <= 1'b0;
            color_q     <= '0;
            coll_q      <= '0;
        end else begin
            if (frame_start) begin
                shadow_q <= oam_data;
            end
            s1_hit_q    <= sel_found;
            s2_hit_q    <= s1_hit_q;
            rom_type_q  <= rom_type_d;
            rom_x_q     <= rom_x_d;
            rom_y_q     <= rom_y_d;
            sprite_on_q <= sprite_on_d;
            color_q     <= color_d;
            coll_q      <= coll_d;
        end
    end

    assign rom_type       = rom_type_q;
    assign rom_x          = rom_x_q;
    assign rom_y          = rom_y_q;
    assign sprite_on      = sprite_on_q;
    assign color          = color_q;
    assign collision_mask = coll_q;

endmodule

// File: tb/tb_sprite_engine_multi.sv
// Directed bench for sprite_engine_multi.
// Hand-computed expectations, one check task, one summary line.
module tb_sprite_engine_multi;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         video_on;
    logic [9:0]   x;
    logic [9:0]   y;
    logic         frame_start;
    logic [255:0] oam_data;
    logic [1:0]   rom_type;
    logic [6:0]   rom_x;
    logic [6:0]   rom_y;
    logic [11:0]  rom_color;
    logic         coll_clr;
    logic         sprite_on;
    logic [11:0]  color;
    logic [7:0]   collision_mask;

    int errors = 0;
    int checks = 0;

    logic [1:0]  cap_rt;
    logic [6:0]  cap_rx;
    logic [6:0]  cap_ry;
    logic        cap_on;
    logic [11:0] cap_co;

    sprite_engine_multi dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .video_on       (video_on),
        .x              (x),
        .y              (y),
        .frame_start    (frame_start),
        .oam_data       (oam_data),
        .rom_type       (rom_type),
        .rom_x          (rom_x),
        .rom_y          (rom_y),
        .rom_color      (rom_color),
        .coll_clr       (coll_clr),
        .sprite_on      (sprite_on),
        .color          (color),
        .collision_mask (collision_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic en, input logic [1:0] ty,
                                        input logic [9:0] px, input logic [9:0] py,
                                        input logic [2:0] row, input logic [2:0] col);
        return {1'b0, ty, en, px, py, 2'b00, row, col};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One pixel at E0, then idle; ROM address captured after E0,
    // drawn result captured after E2
    task automatic probe(input logic [9:0] px, input logic [9:0] py,
                         input logic vo, input logic fs,
                         input logic [11:0] rc);
        x           = px;
        y           = py;
        video_on    = vo;
        frame_start = fs;
        rom_color   = rc;
        tick();
        cap_rt      = rom_type;
        cap_rx      = rom_x;
        cap_ry      = rom_y;
        video_on    = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        cap_on = sprite_on;
        cap_co = color;
    endtask

    initial begin
        rst_n       = 1'b0;
        video_on    = 1'b0;
        x           = '0;
        y           = '0;
        frame_start = 1'b0;
        oam_data    = '0;
        rom_color   = 12'h000;
        coll_clr    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_on",   32'(sprite_on), 32'd0);
        check("rst_col",  32'(color), 32'd0);
        check("rst_mask", 32'(collision_mask), 32'd0);
        check("rst_type", 32'(rom_type), 32'd0);
        check("rst_rx",   32'(rom_x), 32'd0);
        check("rst_ry",   32'(rom_y), 32'd0);

        // 1: basic draw, col=1 -> rom_x = 32 + 5
        oam_data[31:0] = ent(1'b1, 2'd0, 10'd100, 10'd50, 3'd0, 3'd1);
        load_frame();
        probe(10'd105, 10'd60, 1'b1, 1'b0, 12'h0F0);
        check("t1_type", 32'(cap_rt), 32'd0);
        check("t1_rx",   32'(cap_rx), 32'd37);
        check("t1_ry",   32'(cap_ry), 32'd10);
        check("t1_on",   32'(cap_on), 32'd1);
        check("t1_col",  32'(cap_co), 32'h0F0);

        // 2: transparent key
        probe(10'd105, 10'd60, 1'b1, 1'b0, 12'h00F);
        check("t2_on",  32'(cap_on), 32'd0);
        check("t2_col", 32'(cap_co), 32'd0);

        // 3: priority and collision
        oam_data         = '0;
        oam_data[31:0]   = ent(1'b1, 2'd0, 10'd200, 10'd200, 3'd0, 3'd0);
        oam_data[127:96] = ent(1'b1, 2'd1, 10'd210, 10'd210, 3'd0, 3'd0);
        load_frame();
        probe(10'd215, 10'd215, 1'b1, 1'b0, 12'h0F0);
        check("t3_type", 32'(cap_rt), 32'd0);
        check("t3_rx",   32'(cap_rx), 32'd15);
        check("t3_mask", 32'(collision_mask), 32'h09);
        coll_clr = 1'b1;
        tick();
        coll_clr = 1'b0;
        check("t3_clr", 32'(collision_mask), 32'h00);

        // 4: mid-frame OAM change is ignored until frame_start
        oam_data       = '0;
        oam_data[31:0] = ent(1'b1, 2'd0, 10'd400, 10'd300, 3'd0, 3'd0);
        probe(10'd205, 10'd205, 1'b1, 1'b0, 12'h0F0);
        check("t4_old_on", 32'(cap_on), 32'd1);
        check("t4_old_rx", 32'(cap_rx), 32'd5);
        load_frame();
        probe(10'd205, 10'd205, 1'b1, 1'b0, 12'h0F0);
        check("t4_gone", 32'(cap_on), 32'd0);
        probe(10'd405, 10'd305, 1'b1, 1'b0, 12'h0F0);
        check("t4_new_on", 32'(cap_on), 32'd1);
        check("t4_new_rx", 32'(cap_rx), 32'd5);
        check("t4_new_ry", 32'(cap_ry), 32'd5);

        // frame_start on the hit edge still uses the old shadow
        oam_data[31:0] = ent(1'b1, 2'd0, 10'd600, 10'd100, 3'd0, 3'd0);
        probe(10'd405, 10'd305, 1'b1, 1'b1, 12'h0F0);
        check("t4_fs_old", 32'(cap_on), 32'd1);
        probe(10'd605, 10'd105, 1'b1, 1'b0, 12'h0F0);
        check("t4_fs_new", 32'(cap_on), 32'd1);

        // 5: right-edge sprite, no wrap, video_on gating
        oam_data[31:0] = ent(1'b1, 2'd2, 10'd1010, 10'd0, 3'd0, 3'd0);
        load_frame();
        probe(10'd1015, 10'd3, 1'b1, 1'b0, 12'h0F0);
        check("t5_on",   32'(cap_on), 32'd1);
        check("t5_type", 32'(cap_rt), 32'd2);
        check("t5_rx",   32'(cap_rx), 32'd5);
        probe(10'd5, 10'd3, 1'b1, 1'b0, 12'h0F0);
        check("t5_wrap", 32'(cap_on), 32'd0);
        probe(10'd1015, 10'd3, 1'b0, 1'b0, 12'h0F0);
        check("t5_vo", 32'(cap_on), 32'd0);

        // 6: reset mid-sprite flushes everything
        oam_data         = '0;
        oam_data[31:0]   = ent(1'b1, 2'd0, 10'd200, 10'd200, 3'd0, 3'd0);
        oam_data[127:96] = ent(1'b1, 2'd1, 10'd210, 10'd210, 3'd0, 3'd0);
        load_frame();
        x         = 10'd215;
        y         = 10'd215;
        video_on  = 1'b1;
        rom_color = 12'h0F0;
        tick();
        check("t6_pre_mask", 32'(collision_mask), 32'h09);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        video_on = 1'b0;
        tick();
        check("t6_on",   32'(sprite_on), 32'd0);
        check("t6_col",  32'(color), 32'd0);
        check("t6_mask", 32'(collision_mask), 32'd0);
        check("t6_rx",   32'(rom_x), 32'd0);
        probe(10'd215, 10'd215, 1'b1, 1'b0, 12'h0F0);
        check("t6_shadow", 32'(cap_on), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
